gbe_rx_frame_gen: RTL
=====================

Name: gbe_rx_frame_gen

Overview:
- Synthesizable Ethernet/IPv4/UDP frame source that drives the MAC RX side of gbe_udp: mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe.
- Used for on-chip loopback/BIST and as the RX stimulus source in gbe_udp benches.
- Counterpart of the MAC TX ack responder.
- Each start request produces one complete frame with a correct IPv4 header checksum, a payload of programmable length, and a good or bad end-of-frame indication.

Parameters:
- DST_MAC, 48'h123456789abc, destination MAC placed in bytes 0-5.
- SRC_MAC, 48'h02000a0b0c0d, source MAC in bytes 6-11.
- SRC_IP, {8'd192,8'd168,8'd64,8'd1}, IPv4 source address.
- DST_IP, {8'd100,8'd101,8'd102,8'd103}, IPv4 destination address.
- SRC_PORT, 16'hbeef, UDP source port.
- DST_PORT, 16'hdead, UDP destination port.
- IFG, 12, idle cycles after the frame-end strobe before the next start is accepted (valid range 1-255).

Ports:
- mac_rx_clk  in  1  sole clock.
- mac_rx_rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only while busy=0.
- payload_len  in  11  UDP payload bytes; latched on accepted start.
- corrupt  in  1  latched on accepted start; selects badframe instead of goodframe at frame end.
- busy  out  1  high from the cycle after an accepted start through the end of the IFG.
- mac_rx_data  out  8  frame byte.
- mac_rx_dvld  out  1  byte valid.
- mac_rx_goodframe  out  1  one-cycle good end-of-frame strobe.
- mac_rx_badframe  out  1  one-cycle bad end-of-frame strobe.
- frame_count  out  32  number of completed frames (good + bad).

Behaviour:
- Reset: all outputs 0, state IDLE, frame_count 0.
- States: IDLE -> CSUM -> HDR -> PAY -> END -> GAP -> IDLE.
- IDLE: start=1 latches len, corrupt and id=frame_count[15:0], then goes to CSUM.
  - len = min(payload_len, 1472).
  - start while busy=1 is ignored and not queued.
- CSUM: exactly 12 cycles, dvld=0.
  - Cycles 0-9 add the ten 16-bit IPv4 header words (checksum field = 0) into a 20-bit accumulator.
  - Cycles 10-11 each fold: acc = acc[15:0] + acc[19:16].
  - Stored checksum = ~acc[15:0].
- HDR: 42 cycles, dvld=1, byte index b=0..41, MSB-first within every field.
  - b0-5: DST_MAC.
  - b6-11: SRC_MAC.
  - b12-13: 08 00.
  - b14-33: IPv4 header, in order:
    - version/IHL: 45
    - TOS: 00
    - total length: 28+len
    - ID: id
    - flags/fragment: 40 00
    - TTL: 40
    - protocol: 11
    - checksum
    - SRC_IP, DST_IP
  - b34-41: UDP header: SRC_PORT, DST_PORT, length 8+len, checksum 0000.
- PAY: len cycles, dvld=1. Payload byte k = (k + id[7:0]) mod 256. When len=0, PAY is skipped (HDR -> END directly).
- END: 1 cycle, dvld=0.
  - Strobe goodframe (corrupt=0) or badframe (corrupt=1); never both.
  - frame_count increments in this cycle, wrapping at 2^32.
- GAP: IFG cycles, dvld=0, busy=1. Then IDLE with busy=0; start is accepted on the first IDLE cycle.
- Latency: start accepted at edge t gives busy=1 after t, first dvld byte after edge t+13, contiguous dvld for 42+len cycles, then the end strobe.
- mac_rx_data is 8'h00 whenever dvld=0.
- Reset mid-frame: outputs return to 0 at the reset edge. No end strobe, frame_count cleared, partial frame abandoned.
- Width rules:
  - IP total length and UDP length computed in 16 bits; with len ≤ 1472 they cannot overflow.
  - Byte index counter is 11 bits and clears on every state entry.

Decomposition:
- Shared package gbe_pkg:
  - state encoding localparams.
  - ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_UDP = 8'h11, IPV4_TTL = 8'h40.
  - HDR_BYTES = 42, MAX_UDP_PAYLOAD = 1472.
- One sub-module, ipv4_hdr_csum: 20-bit accumulate, 2-cycle fold, complement.
  - Interface: clear, word in, valid in, 16-bit csum out.
  - Reused by the TX path.

Test Plan:
- Reset default: assert mac_rx_rst 4 cycles -> all outputs 0, busy=0, frame_count=0.
- Zero-length frame: payload_len=0, corrupt=0, first frame (id=0), default parameters -> exactly 42 dvld bytes.
  - b24-25 = 6f 5b.
  - b16-17 = 00 1c, b38-39 = 00 08.
  - goodframe exactly one cycle after the last byte; frame_count=1.
- Payload pattern: second frame payload_len=5 -> 47 bytes, payload 01 02 03 04 05 (id=1), IP total length 00 21, badframe=0.
- Corrupt, clamp and ignored start:
  - corrupt=1, payload_len=2047 -> 1514 dvld bytes (len clamped to 1472), UDP length 05 c8, badframe strobe only.
  - start pulses during the frame produce no extra frame.
- Back-to-back timing: start held high continuously -> dvld low exactly 1+IFG+1+12 cycles between frames, frame_count increments by 1 per frame.
- Mid-frame reset: reset at HDR byte 20 -> dvld=0 from the reset edge, no good/bad strobe, next start gives a full frame with id=0.

Source files
------------

// File: rtl/gbe_pkg.sv
// -----------------------------------------------------------------------------
// gbe_pkg
// Shared constants and types for the GbE/IPv4/UDP frame path.
//   - Frame-generator state encoding (state_t)
//   - Protocol constants (ethertype, IP protocol, TTL)
//   - Frame geometry (Ethernet+IPv4+UDP header bytes, max UDP payload)
// -----------------------------------------------------------------------------
package gbe_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CSUM = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_CSUM = S_CSUM,
    ST_HDR  = S_HDR,
    ST_PAY  = S_PAY,
    ST_END  = S_END,
    ST_GAP  = S_GAP
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
  localparam logic [7:0]  IPV4_TTL        = 8'h40;

  localparam logic [10:0] HDR_BYTES       = 11'd42;
  localparam int          HDR_BITS        = 336;
  localparam logic [10:0] MAX_UDP_PAYLOAD = 11'd1472;

  // Checksum phase: ten header words accumulated, then two fold cycles.
  localparam logic [10:0] CSUM_WORDS      = 11'd10;
  localparam logic [10:0] CSUM_CYCLES     = 11'd12;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    return (len > MAX_UDP_PAYLOAD) ? MAX_UDP_PAYLOAD : len;
  endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// -----------------------------------------------------------------------------
// ipv4_hdr_csum
// One's-complement IPv4 header checksum engine.
// Words presented with valid=1 are summed into a 20-bit accumulator. Once valid
// drops, the accumulator folds its carries back in on each of the next two
// cycles; csum is the complement of the low 16 bits and stays stable until
// clear is asserted.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   clear  in   restart accumulation (acc = 0)
//   valid  in   word is a header word to add
//   word   in   16-bit header word
//   csum   out  16-bit header checksum
// -----------------------------------------------------------------------------
module ipv4_hdr_csum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc_reg;
  logic [1:0]  fold_reg;  // fold cycles still owed after the last word

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg  <= '0;
      fold_reg <= '0;
    end else if (valid) begin
      acc_reg  <= acc_reg + {4'd0, word};
      fold_reg <= 2'd2;
    end else if (fold_reg != 2'd0) begin
      acc_reg  <= {4'd0, acc_reg[15:0]} + {16'd0, acc_reg[19:16]};
      fold_reg <= fold_reg - 2'd1;
    end
  end

  assign csum = ~acc_reg[15:0];

endmodule

// File: rtl/gbe_rx_frame_gen.sv
// -----------------------------------------------------------------------------
// gbe_rx_frame_gen
// Ethernet/IPv4/UDP frame source for the MAC RX side (loopback/BIST stimulus).
// Each accepted start emits one frame: 42 header bytes, len payload bytes with
// pattern (k + id[7:0]), then a one-cycle good or bad end-of-frame strobe,
// followed by IFG idle cycles.
// Ports:
//   mac_rx_clk        in   clock
//   mac_rx_rst        in   synchronous active-high reset
//   start             in   frame request, ignored while busy
//   payload_len[11]   in   UDP payload length, clamped to 1472
//   corrupt           in   end frame with badframe instead of goodframe
//   busy              out  frame or inter-frame gap in progress
//   mac_rx_data[8]    out  frame byte (0 when not valid)
//   mac_rx_dvld       out  byte valid
//   mac_rx_goodframe  out  good end-of-frame strobe
//   mac_rx_badframe   out  bad end-of-frame strobe
//   frame_count[32]   out  completed frames
// -----------------------------------------------------------------------------
module gbe_rx_frame_gen #(
  parameter logic [47:0] DST_MAC  = 48'h123456789abc,
  parameter logic [47:0] SRC_MAC  = 48'h02000a0b0c0d,
  parameter logic [31:0] SRC_IP   = {8'd192, 8'd168, 8'd64, 8'd1},
  parameter logic [31:0] DST_IP   = {8'd100, 8'd101, 8'd102, 8'd103},
  parameter logic [15:0] SRC_PORT = 16'hbeef,
  parameter logic [15:0] DST_PORT = 16'hdead,
  parameter int          IFG      = 12
) (
  input  logic        mac_rx_clk,
  input  logic        mac_rx_rst,
  input  logic        start,
  input  logic [10:0] payload_len,
  input  logic        corrupt,
  output logic        busy,
  output logic [7:0]  mac_rx_data,
  output logic        mac_rx_dvld,
  output logic        mac_rx_goodframe,
  output logic        mac_rx_badframe,
  output logic [31:0] frame_count
);

  import gbe_pkg::*;

  localparam logic [10:0] IFG_LAST = 11'(IFG - 1);

  state_t      state_reg, state_next;
  logic [10:0] idx_reg, idx_next;
  logic [10:0] len_reg;
  logic        corrupt_reg;
  logic [15:0] id_reg;
  logic [31:0] frame_count_reg;

  // Outputs are registered, so the wire lags the state by one cycle.
  logic [7:0]  data_reg, data_next;
  logic        dvld_reg, dvld_next;
  logic        good_reg, good_next;
  logic        bad_reg, bad_next;

  logic [15:0] ip_total_len, udp_len, csum, csum_word;
  logic        csum_valid, csum_clear;
  logic [HDR_BITS-1:0] hdr_vec, hdr_shifted;

  assign ip_total_len = 16'd28 + {5'd0, len_reg};
  assign udp_len      = 16'd8 + {5'd0, len_reg};

  // Header words in checksum order; the checksum field itself counts as 0.
  always_comb begin
    csum_word = 16'h0000;
    unique case (idx_reg[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = ip_total_len;
      4'd2:    csum_word = id_reg;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {IPV4_TTL, IP_PROTO_UDP};
      4'd6:    csum_word = SRC_IP[31:16];
      4'd7:    csum_word = SRC_IP[15:0];
      4'd8:    csum_word = DST_IP[31:16];
      4'd9:    csum_word = DST_IP[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  assign csum_clear = (state_reg == ST_IDLE);
  assign csum_valid = (state_reg == ST_CSUM) && (idx_reg < CSUM_WORDS);

  ipv4_hdr_csum u_csum (
    .clk   (mac_rx_clk),
    .rst   (mac_rx_rst),
    .clear (csum_clear),
    .valid (csum_valid),
    .word  (csum_word),
    .csum  (csum)
  );

  // Whole header as one vector, byte 0 in the MSBs.
  assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, ip_total_len, id_reg, 16'h4000,
                    IPV4_TTL, IP_PROTO_UDP, csum, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign hdr_shifted = hdr_vec << {idx_reg[5:0], 3'b000};

  always_comb begin
    state_next = state_reg;
    data_next  = 8'h00;
    dvld_next  = 1'b0;
    good_next  = 1'b0;
    bad_next   = 1'b0;
    unique case (state_reg)
      ST_IDLE: if (start) state_next = ST_CSUM;
      ST_CSUM: if (idx_reg == CSUM_CYCLES - 11'd1) state_next = ST_HDR;
      ST_HDR: begin
        dvld_next = 1'b1;
        data_next = hdr_shifted[HDR_BITS-1 -: 8];
        if (idx_reg == HDR_BYTES - 11'd1)
          state_next = (len_reg == 11'd0) ? ST_END : ST_PAY;
      end
      ST_PAY: begin
        dvld_next = 1'b1;
        data_next = idx_reg[7:0] + id_reg[7:0];
        if (idx_reg == len_reg - 11'd1) state_next = ST_END;
      end
      ST_END: begin
        good_next  = ~corrupt_reg;
        bad_next   = corrupt_reg;
        state_next = ST_GAP;
      end
      ST_GAP:  if (idx_reg == IFG_LAST) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Byte index restarts on every state entry.
    idx_next = ((state_next != state_reg) || (state_reg == ST_IDLE)) ? 11'd0 : idx_reg + 11'd1;
  end

  always_ff @(posedge mac_rx_clk) begin
    if (mac_rx_rst) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      len_reg         <= '0;
      corrupt_reg     <= 1'b0;
      id_reg          <= '0;
      frame_count_reg <= '0;
      data_reg        <= '0;
      dvld_reg        <= 1'b0;
      good_reg        <= 1'b0;
      bad_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      dvld_reg  <= dvld_next;
      good_reg  <= good_next;
      bad_reg   <= bad_next;
      if (state_reg == ST_IDLE && start) begin
        len_reg     <= clamp_len(payload_len);
        corrupt_reg <= corrupt;
        id_reg      <= frame_count_reg[15:0];
      end
      if (state_reg == ST_END) frame_count_reg <= frame_count_reg + 32'd1;
    end
  end

  assign busy             = (state_reg != ST_IDLE);
  assign mac_rx_data      = data_reg;
  assign mac_rx_dvld      = dvld_reg;
  assign mac_rx_goodframe = good_reg;
  assign mac_rx_badframe  = bad_reg;
  assign frame_count      = frame_count_reg;

endmodule
